regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 78 +++++++
 tb/tb_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 31 x WIDTH register file with one write port and two combinational read ports.
// Register X31 has no storage and always reads as zero.
module regfile #(
  parameter int WIDTH = 64,
  parameter int delay = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  localparam int NREGS = 31;
  localparam int NADDR = 32;

  // delay annotates gate-level read/decode timing; the RTL itself is zero-delay.
  generate
    if (delay < 0) begin : g_bad_delay
      $error("regfile: delay must be non-negative");
    end
  endgenerate

  logic [WIDTH-1:0]            regs_q [NREGS];
  logic [WIDTH-1:0]            regs_d [NREGS];
  logic [NREGS-1:0]            wr_sel;
  logic [NADDR-1:0][WIDTH-1:0] rd_view;

  function automatic logic [WIDTH-1:0] read_port(
    input logic [NADDR-1:0][WIDTH-1:0] view,
    input logic [4:0]                  addr
  );
    return view[addr];
  endfunction

  // One-hot write decode; the X31 slot decodes to nothing, so its writes are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_sel[i] = wr_en && (wr_addr == 5'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = wr_sel[i] ? wr_data : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read side sees only registered state, so a same-cycle write is not bypassed.
  always_comb begin
    rd_view = '0;
    for (int i = 0; i < NREGS; i++) begin
      rd_view[i] = regs_q[i];
    end
    rd_view[NADDR-1] = '0;
  end

  always_comb begin
    rd_data1 = read_port(rd_view, rd_addr1);
    rd_data2 = read_port(rd_view, rd_addr2);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed sequences, a vector table and
// randomized traffic checked against an array model of the register file.
module tb_regfile;

  localparam logic [63:0] PAT = 64'h0101010101010101;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [63:0] rd_data1;
  logic [63:0] rd_data2;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t vecs[6];

  regfile #(.WIDTH(64), .delay(50)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'h0 : model[a];
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [4:0] wa,
                            input logic [63:0] wd);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFF, 5'd31, 5'd30, 64'h0, 64'd30 * PAT};
    vecs[1] = '{1'b0, 5'd5,  64'h00000000DEADBEEF, 5'd5,  5'd5,  64'd5 * PAT, 64'd5 * PAT};
    vecs[2] = '{1'b0, 5'd5,  64'h00000000DEADBEEF, 5'd5,  5'd5,  64'd5 * PAT, 64'd5 * PAT};
    vecs[3] = '{1'b0, 5'd5,  64'h00000000DEADBEEF, 5'd5,  5'd4,  64'd5 * PAT, 64'd4 * PAT};
    vecs[4] = '{1'b1, 5'd0,  64'h0123456789ABCDEF, 5'd0,  5'd31, 64'h0123456789ABCDEF, 64'h0};
    vecs[5] = '{1'b1, 5'd30, 64'hFEDCBA9876543210, 5'd30, 5'd0,
                64'hFEDCBA9876543210, 64'h0123456789ABCDEF};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    tick();
    reset = 1'b0;

    // After reset every address reads zero on both ports.
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      check("reset_rd1", rd_data1, 64'h0);
      check("reset_rd2", rd_data2, 64'h0);
    end

    // Fill X0-X30 with i*PAT, read everything back on both ports.
    for (int i = 0; i < 31; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i) * PAT;
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(i);
      #1;
      check("pat_rd1", rd_data1, (i == 31) ? 64'h0 : 64'(i) * PAT);
      check("pat_rd2", rd_data2, (i == 31) ? 64'h0 : 64'(i) * PAT);
    end

    for (int v = 0; v < 6; v++) begin
      wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
      rd_addr1 = vecs[v].ra1; rd_addr2 = vecs[v].ra2;
      tick();
      wr_en = 1'b0;
      #1;
      check("vec_rd1", rd_data1, vecs[v].e1);
      check("vec_rd2", rd_data2, vecs[v].e2);
    end

    // Untouched registers keep their patterns after the X31 write and held-off writes.
    for (int i = 1; i < 30; i++) begin
      rd_addr1 = 5'(i);
      #1;
      check("hold_rd1", rd_data1, 64'(i) * PAT);
    end

    // No bypass: old X7 visible until the edge, new value after it.
    rd_addr1 = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234;
    #1;
    check("nobypass_pre", rd_data1, 64'd7 * PAT);
    tick();
    wr_en = 1'b0;
    check("nobypass_post", rd_data1, 64'h1234);

    // Reset wins over a simultaneous write; write lands on the next edge.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5A5; rd_addr1 = 5'd3;
    rd_addr2 = 5'd7;
    tick();
    check("rst_prio_x3", rd_data1, 64'h0);
    check("rst_prio_x7", rd_data2, 64'h0);
    reset = 1'b0;
    tick();
    wr_en = 1'b0;
    check("post_rst_wr", rd_data1, 64'hA5A5);

    // Reset pulsed between edges has no effect.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst", rd_data1, 64'hA5A5);
    reset = 1'b0;
    tick();
    check("async_rst_edge", rd_data1, 64'hA5A5);

    // Randomized traffic against the array model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    for (int n = 0; n < 400; n++) begin
      logic        r_rst;
      logic        r_we;
      logic [4:0]  r_wa;
      logic [63:0] r_wd;
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = $urandom_range(0, 3) != 0;
      r_wa  = 5'($urandom_range(0, 31));
      r_wd  = {$urandom, $urandom};
      reset = r_rst; wr_en = r_we; wr_addr = r_wa; wr_data = r_wd;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      rd_addr2 = 5'($urandom_range(0, 31));
      #1;
      check("rand_pre_rd1", rd_data1, model_rd(rd_addr1));
      check("rand_pre_rd2", rd_data2, model_rd(rd_addr2));
      tick();
      model_edge(r_rst, r_we, r_wa, r_wd);
      check("rand_post_rd1", rd_data1, model_rd(rd_addr1));
      check("rand_post_rd2", rd_data2, model_rd(rd_addr2));
    end
    reset = 1'b0; wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
